omem_psum_buffer: RTL and testbench

Output-memory partial-sum store that sits directly downstream of the PE array and closes its accumulation loop. It serves per-PE partial sums back to the array on read requests, captures the updated ofmap lanes on out_valid, and masks never-written entries to zero via per-entry valid bits. At layer end it drains the accumulated results channel by channel through a valid/ready port, clearing each entry as it goes.

---
 rtl/omem_psum_buffer.sv | 147 ++++++++++++++
 tb/tb_omem_psum_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/omem_psum_buffer.sv
// Output-memory partial-sum buffer: per-lane psum banks with valid-bit
// masking, same-cycle write-to-read forwarding, and a valid/ready drain
// that streams one channel (all lanes) per beat and clears it on accept.
module omem_psum_buffer #(
  parameter int PE_NUM   = 8,
  parameter int PSUM_W   = 32,
  parameter int CH_DEPTH = 64,
  parameter int CH_W     = $clog2(CH_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pea_out_valid,
  input  logic [PE_NUM*PSUM_W-1:0] pea_ofmap,
  input  logic [PE_NUM*CH_W-1:0]   pea_out_ch,
  input  logic                     rd_req_valid,
  input  logic [PE_NUM*CH_W-1:0]   rd_req_ch,
  output logic                     acc_valid,
  output logic [PE_NUM*PSUM_W-1:0] psum,
  input  logic                     drain_start,
  input  logic [CH_W:0]            drain_len,
  output logic                     drain_valid,
  input  logic                     drain_ready,
  output logic [PE_NUM*PSUM_W-1:0] drain_data,
  output logic [CH_W-1:0]          drain_ch,
  output logic                     drain_last,
  output logic                     drain_done,
  output logic                     busy,
  output logic                     err_sticky
);

  typedef enum logic [1:0] {IDLE, DRAIN_RD, DRAIN_OUT} state_t;

  state_t state, state_nxt;

  logic [PSUM_W-1:0]   mem [PE_NUM][CH_DEPTH];
  logic [CH_DEPTH-1:0] ent_vld [PE_NUM];

  logic [CH_W-1:0]          ch_cnt;
  logic [CH_W:0]            len_q;
  logic [PE_NUM*PSUM_W-1:0] rd_word;
  logic [PE_NUM*PSUM_W-1:0] dr_word;

  logic idle, wr_en, rd_en, start_go, start_zero, hs, last_ch;

  assign idle       = (state == IDLE);
  assign wr_en      = idle & pea_out_valid;
  assign rd_en      = idle & rd_req_valid;
  assign start_go   = idle & drain_start & (drain_len != '0);
  assign start_zero = idle & drain_start & (drain_len == '0);
  assign hs         = (state == DRAIN_OUT) & drain_ready;
  assign last_ch    = ({1'b0, ch_cnt} == (len_q - (CH_W+1)'(1)));

  assign busy        = ~idle;
  assign drain_valid = (state == DRAIN_OUT);
  assign drain_last  = drain_valid & last_ch;
  assign drain_ch    = ch_cnt;

  // Per-lane read muxes: forwarded write data wins, else valid-masked entry
  for (genvar g = 0; g < PE_NUM; g++) begin : g_lane
    logic [CH_W-1:0]   w_ch;
    logic [CH_W-1:0]   r_ch;
    logic [PSUM_W-1:0] w_dat;
    assign w_ch  = pea_out_ch[g*CH_W +: CH_W];
    assign r_ch  = rd_req_ch[g*CH_W +: CH_W];
    assign w_dat = pea_ofmap[g*PSUM_W +: PSUM_W];
    assign rd_word[g*PSUM_W +: PSUM_W] =
      (wr_en && (w_ch == r_ch)) ? w_dat :
      (ent_vld[g][r_ch] ? mem[g][r_ch] : '0);
    assign dr_word[g*PSUM_W +: PSUM_W] =
      ent_vld[g][ch_cnt] ? mem[g][ch_cnt] : '0;
  end

  // Data banks: written only from the PE array while idle, never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < PE_NUM; i++)
        mem[i][pea_out_ch[i*CH_W +: CH_W]] <= pea_ofmap[i*PSUM_W +: PSUM_W];
    end
  end

  // Valid bits: set on write, cleared for the drained channel on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PE_NUM; i++) ent_vld[i] <= '0;
    end else begin
      for (int i = 0; i < PE_NUM; i++) begin
        if (wr_en)
          ent_vld[i][pea_out_ch[i*CH_W +: CH_W]] <= 1'b1;
        else if (hs)
          ent_vld[i][ch_cnt] <= 1'b0;
      end
    end
  end

  // Psum return path to the PE array, one-cycle latency, holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid <= 1'b0;
      psum      <= '0;
    end else begin
      acc_valid <= rd_en;
      if (rd_en) psum <= rd_word;
    end
  end

  // Drain state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Drain next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_go) state_nxt = DRAIN_RD;
      DRAIN_RD:  state_nxt = DRAIN_OUT;
      DRAIN_OUT: if (hs) state_nxt = last_ch ? IDLE : DRAIN_RD;
      default:   state_nxt = IDLE;
    endcase
  end

  // Drain channel counter, beat register, done pulse and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt     <= '0;
      len_q      <= '0;
      drain_data <= '0;
      drain_done <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (start_go) begin
        ch_cnt <= '0;
        len_q  <= drain_len;
      end else if (hs && !last_ch) begin
        ch_cnt <= ch_cnt + CH_W'(1);
      end
      if (state == DRAIN_RD) drain_data <= dr_word;
      drain_done <= start_zero | (hs & last_ch);
      if (idle && drain_start)
        err_sticky <= 1'b0;
      else if (!idle && (pea_out_valid || rd_req_valid))
        err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_omem_psum_buffer.sv
// Directed bench for omem_psum_buffer: read masking, forwarding, drain
// with back-pressure, busy-time error flag and asynchronous reset abort.
module tb_omem_psum_buffer;

  localparam int PE_NUM   = 8;
  localparam int PSUM_W   = 32;
  localparam int CH_DEPTH = 64;
  localparam int CH_W     = 6;
  localparam int VW       = PE_NUM*PSUM_W;

  logic                   clk;
  logic                   rst_n;
  logic                   pea_out_valid;
  logic [VW-1:0]          pea_ofmap;
  logic [PE_NUM*CH_W-1:0] pea_out_ch;
  logic                   rd_req_valid;
  logic [PE_NUM*CH_W-1:0] rd_req_ch;
  logic                   acc_valid;
  logic [VW-1:0]          psum;
  logic                   drain_start;
  logic [CH_W:0]          drain_len;
  logic                   drain_valid;
  logic                   drain_ready;
  logic [VW-1:0]          drain_data;
  logic [CH_W-1:0]        drain_ch;
  logic                   drain_last;
  logic                   drain_done;
  logic                   busy;
  logic                   err_sticky;

  int n_chk = 0;
  int n_fail = 0;

  omem_psum_buffer #(.PE_NUM(PE_NUM), .PSUM_W(PSUM_W), .CH_DEPTH(CH_DEPTH), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pea_out_valid(pea_out_valid), .pea_ofmap(pea_ofmap), .pea_out_ch(pea_out_ch),
    .rd_req_valid(rd_req_valid), .rd_req_ch(rd_req_ch),
    .acc_valid(acc_valid), .psum(psum),
    .drain_start(drain_start), .drain_len(drain_len),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_data(drain_data),
    .drain_ch(drain_ch), .drain_last(drain_last), .drain_done(drain_done),
    .busy(busy), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PE_NUM*CH_W-1:0] rep_ch(input int c);
    logic [PE_NUM*CH_W-1:0] r;
    for (int i = 0; i < PE_NUM; i++) r[i*CH_W +: CH_W] = CH_W'(c);
    return r;
  endfunction

  function automatic logic [VW-1:0] fill_vec(input int c);
    logic [VW-1:0] v;
    for (int i = 0; i < PE_NUM; i++) v[i*PSUM_W +: PSUM_W] = 32'h1000_0000 | (c << 8) | i;
    return v;
  endfunction

  task automatic write_all(input logic [VW-1:0] d, input logic [PE_NUM*CH_W-1:0] c);
    pea_out_valid = 1'b1;
    pea_ofmap     = d;
    pea_out_ch    = c;
    tick();
    pea_out_valid = 1'b0;
  endtask

  task automatic read_ch(input string tag, input int c, input logic [VW-1:0] exp);
    rd_req_valid = 1'b1;
    rd_req_ch    = rep_ch(c);
    tick();
    rd_req_valid = 1'b0;
    check({tag, "_acc_valid"}, VW'(acc_valid), VW'(1));
    check({tag, "_psum"}, psum, exp);
  endtask

  task automatic wait_valid(input string tag, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (drain_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_wait_drain_valid"}, VW'(ok), VW'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc_valid"},   VW'(acc_valid),   '0);
    check({tag, "_psum"},        psum,             '0);
    check({tag, "_drain_valid"}, VW'(drain_valid), '0);
    check({tag, "_drain_data"},  drain_data,       '0);
    check({tag, "_drain_ch"},    VW'(drain_ch),    '0);
    check({tag, "_drain_last"},  VW'(drain_last),  '0);
    check({tag, "_drain_done"},  VW'(drain_done),  '0);
    check({tag, "_busy"},        VW'(busy),        '0);
    check({tag, "_err_sticky"},  VW'(err_sticky),  '0);
  endtask

  initial begin
    logic [VW-1:0] d, e;
    bit rdy, hs;
    int b;

    rst_n = 1'b0; pea_out_valid = 1'b0; pea_ofmap = '0; pea_out_ch = '0;
    rd_req_valid = 1'b0; rd_req_ch = '0; drain_start = 1'b0; drain_len = '0;
    drain_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Never-written entries read as zero
    read_ch("rd_empty", 5, '0);
    tick();
    check("acc_valid_drop", VW'(acc_valid), '0);

    // Lane 0 / lane 7 at ch 3, others parked on ch 40
    d = '0;
    for (int i = 1; i < 7; i++) d[i*PSUM_W +: PSUM_W] = 32'h500 + i;
    d[0*PSUM_W +: PSUM_W] = 32'h10;
    d[7*PSUM_W +: PSUM_W] = 32'h20;
    pea_out_ch = rep_ch(40);
    pea_out_ch[0*CH_W +: CH_W] = 6'd3;
    pea_out_ch[7*CH_W +: CH_W] = 6'd3;
    write_all(d, pea_out_ch);
    e = '0;
    e[0*PSUM_W +: PSUM_W] = 32'h10;
    e[7*PSUM_W +: PSUM_W] = 32'h20;
    read_ch("rd_ch3", 3, e);
    e = '0;
    for (int i = 1; i < 7; i++) e[i*PSUM_W +: PSUM_W] = 32'h500 + i;
    read_ch("rd_ch40", 40, e);

    // Forwarding: write lane 2 ch 9 and read ch 9 in the same cycle
    d = '0;
    for (int i = 0; i < PE_NUM; i++) d[i*PSUM_W +: PSUM_W] = 32'h600 + i;
    d[2*PSUM_W +: PSUM_W] = 32'hABCD;
    pea_out_valid = 1'b1;
    pea_ofmap     = d;
    pea_out_ch    = rep_ch(41);
    pea_out_ch[2*CH_W +: CH_W] = 6'd9;
    e = '0;
    e[2*PSUM_W +: PSUM_W] = 32'hABCD;
    read_ch("fwd_ch9", 9, e);
    pea_out_valid = 1'b0;
    tick();
    check("psum_hold_valid", VW'(acc_valid), '0);
    check("psum_hold", psum, e);

    // Fill ch 0..3 and drain with toggling ready
    for (int c = 0; c < 4; c++) write_all(fill_vec(c), rep_ch(c));
    drain_start = 1'b1; drain_len = 7'd4;
    tick();
    drain_start = 1'b0;
    check("drain_busy", VW'(busy), VW'(1));
    check("drain_first_bubble", VW'(drain_valid), '0);
    rdy = 1'b1; b = 0;
    for (int cyc = 0; cyc < 40 && b < 4; cyc++) begin
      drain_ready = rdy;
      hs = drain_valid && rdy;
      if (drain_valid) begin
        check("beat_ch", VW'(drain_ch), VW'(b));
        check("beat_data", drain_data, fill_vec(b));
        check("beat_last", VW'(drain_last), VW'(b == 3));
      end
      tick();
      if (hs) begin
        b++;
        check("beat_done", VW'(drain_done), VW'(b == 4));
      end
      rdy = ~rdy;
    end
    drain_ready = 1'b0;
    check("drain_beats", VW'(b), VW'(4));
    check("drain_end_busy", VW'(busy), '0);
    check("drain_end_valid", VW'(drain_valid), '0);
    tick();
    check("drain_done_pulse", VW'(drain_done), '0);
    for (int c = 0; c < 4; c++) read_ch("rd_cleared", c, '0);

    // Traffic while busy is ignored and flagged
    d = '0;
    for (int i = 0; i < PE_NUM; i++) d[i*PSUM_W +: PSUM_W] = 32'h77 + i;
    write_all(d, rep_ch(10));
    drain_start = 1'b1; drain_len = 7'd1;
    tick();
    drain_start = 1'b0;
    pea_out_valid = 1'b1; pea_ofmap = {PE_NUM{32'hDEAD}}; pea_out_ch = rep_ch(10);
    rd_req_valid = 1'b1; rd_req_ch = rep_ch(10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("busy_acc_valid", VW'(acc_valid), '0);
    end
    check("err_set", VW'(err_sticky), VW'(1));
    wait_valid("err", 8);
    check("err_beat_data", drain_data, '0);
    drain_ready = 1'b1; pea_out_valid = 1'b0; rd_req_valid = 1'b0;
    tick();
    drain_ready = 1'b0;
    check("err_drain_done", VW'(drain_done), VW'(1));
    check("err_still_set", VW'(err_sticky), VW'(1));
    read_ch("rd_unchanged", 10, d);
    drain_start = 1'b1; drain_len = '0;
    tick();
    drain_start = 1'b0;
    check("len0_done", VW'(drain_done), VW'(1));
    check("len0_err_clear", VW'(err_sticky), '0);
    check("len0_busy", VW'(busy), '0);

    // Asynchronous reset during a live drain beat
    write_all(fill_vec(5), rep_ch(5));
    drain_start = 1'b1; drain_len = 7'd8;
    tick();
    drain_start = 1'b0;
    wait_valid("rst", 8);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_done", VW'(drain_done), '0);
      check("rst_idle", VW'(busy), '0);
    end
    read_ch("rd_after_rst", 5, '0);
    read_ch("rd_after_rst40", 40, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
